// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the shared-multiplier sequencer.
// Optional feature macro: MULT_ZERO_SKIP_EN (see mult_share_sequencer).
package mult_seq_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // First set request at or above ptr, wrapping at n-1 -> 0. Supports n up to 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [2:0] pick;
    logic       found;
    int         cand;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = int'(ptr) + k;
      if (cand >= n) cand = cand - n;
      else cand = cand;
      if ((k < n) && !found && req[cand[2:0]]) begin
        pick  = cand[2:0];
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/eight_bit_array_multiplier.sv
// Combinational unsigned 8x8 array multiplier: rows of shifted partial
// products accumulated in a ripple chain. Deliberately not pipelined; the
// sequencer gives it a multicycle settle window.
module eight_bit_array_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] s
);

  logic [15:0] acc_s;

  // Accumulate one partial-product row per multiplier bit.
  always_comb begin
    acc_s = 16'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc_s = acc_s + ({8'd0, a} << i);
      else acc_s = acc_s;
    end
    s = acc_s;
  end

endmodule

// File: rtl/mult_share_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus its index, searching
// upward from ptr with wrap-around.
module rr_arbiter
  import mult_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [7:0] req8_s;
  logic [2:0] ptr3_s;
  logic [2:0] pick_s;

  // Widen to the helper's fixed 8-entry form and decode the winner.
  always_comb begin
    req8_s         = 8'd0;
    req8_s[N-1:0]  = req;
    ptr3_s         = 3'd0;
    ptr3_s[IW-1:0] = ptr;
    pick_s         = rr_pick(req8_s, ptr3_s, N);
    any            = |req;
    idx            = pick_s[IW-1:0];
    grant          = {N{1'b0}};
    if (any) grant[idx] = 1'b1;
    else grant = {N{1'b0}};
  end

endmodule

// File: rtl/mult_share_sequencer.sv
// Shares one combinational 8x8 array multiplier between NUM_REQ requesters
// with round-robin arbitration and a MULT_CYCLES settle window before the
// product is captured. Results leave on one valid/ready channel tagged by id.
// Optional: define MULT_ZERO_SKIP_EN to answer zero-operand requests directly
// from IDLE (skips the settle window).
module mult_share_sequencer
  import mult_seq_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MULT_CYCLES = 2,
  parameter int ID_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_a,
  input  logic [OP_W*NUM_REQ-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_p
);

  localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  state_t              state_r, next_state_s;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [OP_W-1:0]     op_a_r, op_b_r;
  logic [ID_W-1:0]     op_id_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     grant_idx_s;
  logic                grant_any_s;
  logic [OP_W-1:0]     sel_a_s, sel_b_s;
  logic                zero_s;
  logic [PROD_W-1:0]   prod_s;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .idx   (grant_idx_s),
    .any   (grant_any_s)
  );

  eight_bit_array_multiplier u_mult (
    .a (op_a_r),
    .b (op_b_r),
    .s (prod_s)
  );

  // Select the winner's operands and flag zero operands for the fast path.
  always_comb begin
    sel_a_s = req_a[grant_idx_s*OP_W +: OP_W];
    sel_b_s = req_b[grant_idx_s*OP_W +: OP_W];
`ifdef MULT_ZERO_SKIP_EN
    zero_s  = (sel_a_s == 8'd0) || (sel_b_s == 8'd0);
`else
    zero_s  = 1'b0;
`endif
  end

  // Grant is visible only while IDLE and out of reset.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if ((state_r == IDLE) && !rst) req_ready = grant_s;
    else req_ready = {NUM_REQ{1'b0}};
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_any_s) next_state_s = zero_s ? HOLD : CALC;
        else next_state_s = IDLE;
      end
      CALC: begin
        if (cnt_r == {CNT_W{1'b0}}) next_state_s = HOLD;
        else next_state_s = CALC;
      end
      HOLD: begin
        if (rsp_ready) next_state_s = IDLE;
        else next_state_s = HOLD;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else state_r <= next_state_s;
  end

  // Operand capture, settle countdown, response registers and rr pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r  <= {ID_W{1'b0}};
      op_a_r    <= 8'd0;
      op_b_r    <= 8'd0;
      op_id_r   <= {ID_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      rsp_valid <= 1'b0;
      rsp_id    <= {ID_W{1'b0}};
      rsp_p     <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            op_a_r  <= sel_a_s;
            op_b_r  <= sel_b_s;
            op_id_r <= grant_idx_s;
            cnt_r   <= CNT_INIT;
            if (zero_s) begin
              rsp_p     <= 16'd0;
              rsp_id    <= grant_idx_s;
              rsp_valid <= 1'b1;
            end
          end
        end
        CALC: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            rsp_p     <= prod_s;
            rsp_id    <= op_id_r;
            rsp_valid <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr_r  <= (op_id_r == LAST_ID) ? {ID_W{1'b0}} : op_id_r + ID_W'(1);
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_sequencer.sv
// Directed self-checking bench for mult_share_sequencer (NUM_REQ=4, MULT_CYCLES=2).
module tb_mult_share_sequencer;

  localparam int MC = 2;
`ifdef MULT_ZERO_SKIP_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = MC;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_p;

  int checks = 0;
  int errors = 0;

  mult_share_sequencer #(.NUM_REQ(4), .MULT_CYCLES(MC), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
  endtask

  // Called right after tick(); ends at the negedge of the first HOLD cycle.
  task automatic serve(input int id, input int exp_p, input int exp_lat, input bit keep, input string tag);
    int n;
    @(negedge clk);
    check({tag, ".rsp_idle"}, 32'(rsp_valid), 32'd0);
    check({tag, ".grant"}, 32'(req_ready), 32'(1) << id);
    tick();
    if (!keep) req_valid[id] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(exp_lat));
    check({tag, ".id"}, 32'(rsp_id), 32'(id));
    check({tag, ".p"}, 32'(rsp_p), 32'(exp_p));
  endtask

  initial begin
    int id;
    logic [7:0] ra, rb;
    bit stall;

    rst = 1'b1; req_valid = 4'hF; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("reset.req_ready", 32'(req_ready), 32'd0);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_id", 32'(rsp_id), 32'd0);
    check("reset.rsp_p", 32'(rsp_p), 32'd0);
    tick();
    req_valid = 4'h0;
    rst = 1'b0;
    tick();

    // Contention: all held valid, service must rotate 0,1,2,3,0.
    set_op(0, 8'd3, 8'd5); set_op(1, 8'd7, 8'd9);
    set_op(2, 8'd255, 8'd255); set_op(3, 8'd16, 8'd16);
    req_valid = 4'hF;
    serve(0, 15, MC, 1'b1, "cont0");
    tick(); serve(1, 63, MC, 1'b1, "cont1");
    tick(); serve(2, 65025, MC, 1'b1, "cont2");
    tick(); serve(3, 256, MC, 1'b1, "cont3");
    tick(); serve(0, 15, MC, 1'b1, "cont4");
    tick();
    req_valid = 4'h0;
    tick();

    // Single request on requester 1 (ptr is 1 now).
    set_op(1, 8'd12, 8'd13);
    req_valid = 4'b0010;
    serve(1, 156, MC, 1'b0, "single");
    tick();
    @(negedge clk);
    check("single.drop_valid", 32'(rsp_valid), 32'd0);
    check("single.drop_ready", 32'(req_ready), 32'd0);
    tick();

    // Backpressure with requester 3 waiting.
    rsp_ready = 1'b0;
    set_op(2, 8'd100, 8'd200);
    req_valid = 4'b0100;
    serve(2, 20000, MC, 1'b0, "bp");
    set_op(3, 8'd9, 8'd11);
    req_valid = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check("bp.hold_valid", 32'(rsp_valid), 32'd1);
      check("bp.hold_p", 32'(rsp_p), 32'd20000);
      check("bp.hold_id", 32'(rsp_id), 32'd2);
      check("bp.hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    serve(3, 99, MC, 1'b0, "bp_next");
    tick();

    // Zero operand on requester 1 (ptr 0 -> leaves ptr at 2).
    set_op(1, 8'd0, 8'd200);
    req_valid = 4'b0010;
    serve(1, 0, ZLAT, 1'b0, "zero");
    tick();

    // Reset in CALC: no response, pointer back to 0.
    set_op(2, 8'd5, 8'd6);
    req_valid = 4'b0100;
    @(negedge clk);
    check("rcalc.grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rcalc.no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    set_op(0, 8'd2, 8'd3); set_op(3, 8'd4, 8'd4);
    req_valid = 4'b1001;
    serve(0, 6, MC, 1'b0, "rcalc_r0");
    tick();
    serve(3, 16, MC, 1'b0, "rcalc_r3");

    // Random single-requester operations with occasional backpressure.
    for (int i = 0; i < 40; i++) begin
      tick();
      id = int'($urandom_range(0, 3));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      stall = 1'($urandom_range(0, 1));
      set_op(id, ra, rb);
      req_valid = 4'(1 << id);
      rsp_ready = !stall;
      serve(id, int'(ra) * int'(rb), ((ra == 8'd0) || (rb == 8'd0)) ? ZLAT : MC, 1'b0, "rand");
      if (stall) begin
        tick(); tick();
        @(negedge clk);
        check("rand.stall_p", 32'(rsp_p), 32'(int'(ra) * int'(rb)));
        rsp_ready = 1'b1;
      end
    end
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
